// File: rtl/mont_mult_iter.sv
// Bit-serial radix-2 Montgomery multiplier: result = X*Y*2^(-N) mod M.
// One iteration per clock, then a single conditional-subtract cycle. Even moduli are rejected.
module mont_mult_iter #(
    parameter int unsigned N     = 6,
    parameter int unsigned CNT_W = $clog2(N + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] X,
    input  logic [N-1:0] Y,
    input  logic [N-1:0] M,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         err
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ITER   = 2'd1,
        FINAL  = 2'd2,
        REJECT = 2'd3
    } state_t;

    state_t           state;
    logic [N-1:0]     x_sh;
    logic [N-1:0]     y_lat;
    logic [N-1:0]     m_lat;
    logic [N:0]       s;
    logic [CNT_W-1:0] i;

    logic             xi;
    logic             q;
    logic [N+1:0]     sum;
    logic [N:0]       diff;
    logic             s_ge_m;
    logic             unused_bits;

    // The latched multiplier is shifted right each iteration, so bit i is always at x_sh[0].
    assign xi     = x_sh[0];
    assign q      = s[0] ^ (xi & y_lat[0]);
    assign sum    = {1'b0, s}
                  + ({(N + 2){xi}} & {2'b00, y_lat})
                  + ({(N + 2){q}}  & {2'b00, m_lat});
    assign diff   = s - {1'b0, m_lat};
    assign s_ge_m = (s >= {1'b0, m_lat});

    // sum[0] is zero by construction of q; diff[N] is dropped when s >= M.
    assign unused_bits = ^{sum[0], diff[N]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
            s      <= '0;
            i      <= '0;
            x_sh   <= '0;
            y_lat  <= '0;
            m_lat  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (M[0]) begin
                            x_sh  <= X;
                            y_lat <= Y;
                            m_lat <= M;
                            s     <= '0;
                            i     <= '0;
                            busy  <= 1'b1;
                            state <= ITER;
                        end else begin
                            state <= REJECT;
                        end
                    end
                end
                ITER: begin
                    s    <= sum[N+1:1];
                    x_sh <= x_sh >> 1;
                    i    <= i + CNT_W'(1);
                    if (i == LAST_ITER) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    result <= s_ge_m ? diff[N-1:0] : s[N-1:0];
                    err    <= 1'b0;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                REJECT: begin
                    result <= '0;
                    err    <= 1'b1;
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mult_iter.sv
// Scoreboard bench for mont_mult_iter (N=6): stimulus pushes expected {err,result},
// a monitor pops and compares on every done pulse.
module tb_mont_mult_iter;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] X, Y, M;
    logic         busy, done, err;
    logic [N-1:0] result;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [N:0] exp_q[$];
    logic prev_done = 1'b0;

    mont_mult_iter #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .X(X), .Y(Y), .M(M),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    // Independent reference: brute-force r with r*2^N == x*y (mod m).
    function automatic int mont_ref(int x, int y, int m);
        int p;
        p = (x * y) % m;
        for (int r = 0; r < m; r++)
            if (((r << N) % m) == p) return r;
        return -1;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Monitor: compare every done pulse against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: got result=%0d err=%0d expected no done", result, err);
                end else begin
                    logic [N:0] e;
                    e = exp_q.pop_front();
                    if ({err, result} !== e) begin
                        n_fail++;
                        $display("FAIL result: got err=%0d result=%0d expected err=%0d result=%0d",
                                 err, result, e[N], e[N-1:0]);
                    end
                end
                if (prev_done) begin
                    n_fail++;
                    $display("FAIL done_pulse: got done high 2 cycles expected 1");
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    task automatic issue(input int x, input int y, input int m, input int er, input int ee, input bit push);
        @(negedge clk);
        X = N'(x); Y = N'(y); M = N'(m); start = 1'b1;
        if (push) exp_q.push_back({ee[0], er[N-1:0]});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done starting from the negedge after acceptance; returns latency and busy cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat = 0; bcnt = 0;
        while (!done && lat < 50) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: got no done after %0d cycles expected done", lat);
        end
    endtask

    initial begin
        int lat, bcnt, t, last_t, x, y, m;
        rst = 1'b1; start = 1'b0; X = '0; Y = '0; M = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;

        // Basic op with latency and busy-width checks.
        issue(5, 7, 13, 4, 0, 1);
        wait_done(lat, bcnt);
        chk("latency", lat, 7);
        chk("busy_cycles", bcnt, 7);
        chk("busy_at_done", int'(busy), 0);

        issue(12, 7, 13, 7, 0, 1);  wait_done(lat, bcnt);
        issue(1, 1, 13, 12, 0, 1);  wait_done(lat, bcnt);
        issue(0, 9, 13, 0, 0, 1);   wait_done(lat, bcnt);
        issue(62, 62, 63, 1, 0, 1); wait_done(lat, bcnt);

        // Even modulus rejected, then a normal op.
        issue(5, 7, 12, 0, 1, 1);
        wait_done(lat, bcnt);
        chk("reject_latency", lat, 1);
        chk("reject_busy", bcnt, 0);
        issue(5, 7, 13, 4, 0, 1); wait_done(lat, bcnt);
        chk("err_cleared", int'(err), 0);

        // Back-to-back with start held high, new operands loaded in each done cycle.
        @(negedge clk);
        X = 6'd5; Y = 6'd7; M = 6'd13; start = 1'b1;
        exp_q.push_back({1'b0, 6'(mont_ref(5, 7, 13))});
        t = 0; last_t = -1;
        for (int k = 0; k < 4; k++) begin
            int w;
            w = 0;
            @(negedge clk); t++;
            while (!done && w < 30) begin @(negedge clk); t++; w++; end
            if (last_t >= 0) chk("b2b_period", t - last_t, 8);
            last_t = t;
            if (k < 3) begin
                x = 3 + k; y = 10 - k; m = 11 + 2 * k;
                X = N'(x); Y = N'(y); M = N'(m);
                exp_q.push_back({1'b0, 6'(mont_ref(x, y, m))});
            end else begin
                start = 1'b0;
            end
        end

        // Operand changes and start pulses while busy must be ignored.
        issue(9, 11, 17, mont_ref(9, 11, 17), 0, 1);
        for (int k = 0; k < 3; k++) begin
            X = 6'(k + 1); Y = 6'(k + 2); M = 6'd61;
            start = (k == 1);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(lat, bcnt);
        repeat (12) @(negedge clk);

        // Reset mid-operation aborts with no done.
        issue(5, 7, 13, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_result", int'(result), 0);
        chk("abort_err", int'(err), 0);
        repeat (12) @(negedge clk);
        issue(5, 7, 13, 4, 0, 1); wait_done(lat, bcnt);

        // Randomised legal operands.
        for (int k = 0; k < 200; k++) begin
            m = 2 * $urandom_range(1, 31) + 1;
            x = $urandom_range(0, m - 1);
            y = $urandom_range(0, m - 1);
            issue(x, y, m, mont_ref(x, y, m), 0, 1);
            wait_done(lat, bcnt);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mont_mult_iter.md
Name: mont_mult_iter

Overview:
- Parametrised, bit-serial radix-2 Montgomery modular multiplier with a start/done handshake and an on-chip final conditional subtraction.
- Computes RESULT = X*Y*2^(-N) mod M for any odd modulus of width N.
- Replaces the fixed 6-bit, 2-kernel chained datapath in the modular-arithmetic subsystem.
- Sits between the operand register file and the exponentiation controller.

Parameters:
N, 6, operand, modulus and result width in bits; legal range is 2 or more.
CNT_W, $clog2(N+1), width of the iteration counter (derived; do not override).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only while in IDLE
X  input  N  multiplier operand; requires X < M
Y  input  N  multiplicand operand; requires Y < M
M  input  N  modulus; must be odd
busy  output  1  high while an operation is in flight (ITER or FINAL)
done  output  1  one-cycle pulse when result/err become valid
result  output  N  Montgomery product; held until the next done pulse
err  output  1  set with done when the operation was rejected; held like result

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst overrides everything, including mid-operation.
- Reset values:
  - state = IDLE
  - busy = 0, done = 0, result = 0, err = 0
  - internal accumulator S = 0, counter i = 0
  - latched operands = 0
- States: IDLE, ITER, FINAL, REJECT.
- IDLE:
  - start=1 and M[0]=1: latch X, Y and M; clear S and i; go to ITER; busy goes high next cycle.
  - start=1 and M[0]=0: go to REJECT.
  - start=0: stay in IDLE.
  - Operand inputs are ignored outside the accepting edge. Later changes to X, Y or M do not affect an in-flight operation.
- ITER, one iteration per clock, with xi = Xlat[i]:
  - q = S[0] XOR (xi AND Ylat[0])
  - S <= (S + xi*Ylat + q*Mlat) >> 1
  - i <= i+1
  - After the edge where i = N-1 is processed, go to FINAL.
  - Exactly N ITER cycles per operation.
- Widths:
  - S is N+1 bits wide and the pre-shift sum is N+2 bits wide.
  - Invariant: S < 2*Mlat after every iteration, given X, Y < M. No overflow is permitted.
- FINAL, one cycle:
  - result <= (S >= Mlat) ? S - Mlat : S, truncated to N bits.
  - err <= 0, done <= 1, go to IDLE.
  - The comparison uses >= (not >), so the result is always < M.
- REJECT, one cycle:
  - result <= 0, err <= 1, done <= 1, go to IDLE.
  - busy stays 0 throughout a rejection.
- Latency:
  - Start accepted at edge k gives done = 1 in the cycle following edge k+N+1. That is N+1 clocks from start to done.
  - Rejection: done follows edge k+1.
- busy is 1 exactly in ITER and FINAL cycles. It deasserts in the same cycle that done asserts.
- start while busy=1 is ignored and not queued. A start asserted during the done cycle is accepted (state is IDLE), giving back-to-back throughput of one operation per N+2 cycles.
- done is a single-cycle pulse. result and err hold their values until the next done or until reset.
- Reset mid-operation aborts the operation: no done pulse, and all outputs return to their reset values on the next edge.
- Violating X, Y < M gives an undefined result value. Handshake timing is still guaranteed in that case.

Test Plan:
- N=6, M=13, X=5, Y=7, start for 1 cycle -> busy for 7 cycles; done at start+7; result=4, err=0.
- N=6, M=13, X=12 (R mod M), Y=7 -> result=7 (identity). Then X=1, Y=1 -> result=12 (R^-1 mod 13).
- N=6, M=13, X=0, Y=9 -> result=0. Then M=63, X=62, Y=62 -> result < 63 and equals a golden-model value, which checks the final subtraction with S >= M.
- M=12 (even), start -> done one cycle later with err=1, result=0, busy never high. A following start with M=13, X=5, Y=7 -> result=4, err=0.
- Assert start continuously with new operands each done cycle -> one done every 8 cycles, each result matching the model. Toggling X/Y/M while busy has no effect. rst at iteration 3 -> no done; outputs return to 0; the next start completes normally.
- Randomised, N=6 and N=16: 1000 operations with random odd M and X, Y < M -> result == (X*Y*inv(2^N)) mod M for every operation.
